// File: rtl/fft_seq_pkg.sv
// Shared types for the FFT frame sequencer: bank lifecycle states and per-bank frame descriptors.
package fft_seq_pkg;

    localparam int unsigned LOG2LEN_MIN = 3;
    localparam int unsigned BFP_W       = 8;

    typedef enum logic [2:0] {
        BankFree    = 3'd0,
        BankFilling = 3'd1,
        BankFull    = 3'd2,
        BankRunning = 3'd3,
        BankDone    = 3'd4
    } bank_state_t;

    typedef struct packed {
        logic [3:0]       log2len;
        logic             ifft;
        logic [BFP_W-1:0] bfpexp;
    } bank_desc_t;

    function automatic logic [3:0] clamp_log2len(input logic [3:0] req, input logic [3:0] max_len);
        if (req < 4'(LOG2LEN_MIN)) begin
            return 4'(LOG2LEN_MIN);
        end
        if (req > max_len) begin
            return max_len;
        end
        return req;
    endfunction

endpackage

// File: rtl/var_bitrev_counter.sv
// Sample counter for a runtime-selected frame length 2^L; emits the bit-reversed write address
// and flags the last sample of the frame.
module var_bitrev_counter
    import fft_seq_pkg::*;
#(
    parameter int unsigned N = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic [3:0]   log2len_i,
    output logic [N-1:0] count_o,
    output logic [N-1:0] addr_o,
    output logic         last_o
);

    logic [N-1:0] count_q, count_d;
    logic [N-1:0] rev;
    logic [N-1:0] mask;

    always_comb begin
        rev = '0;
        for (int i = 0; i < N; i++) begin
            rev[i] = count_q[N-1-i];
        end
    end

    // count stays below 2^L, so shifting the full reversal down leaves only the low L bits
    assign addr_o  = rev >> (4'(N) - log2len_i);
    assign mask    = N'((32'd1 << log2len_i) - 32'd1);
    assign last_o  = (count_q == mask);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Round-robin multi-bank frame sequencer: overlaps input fill, engine runs and result readout,
// keeping each frame's length, direction and block exponent until the frame is released.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned  FFT_MAX_LENGTH = 1024,
    parameter int unsigned  FFT_DW         = 16,
    parameter int unsigned  NUM_BANKS      = 2,
    parameter int unsigned  BANK_BW        = 2,
    localparam int unsigned FFT_N          = $clog2(FFT_MAX_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             cfg_log2len,
    input  logic                   autorun,
    input  logic                   run,
    input  logic                   ifft,
    input  logic                   fin,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [FFT_DW-1:0]      s_real,
    input  logic [FFT_DW-1:0]      s_imag,
    output logic                   wact_in,
    output logic [BANK_BW-1:0]     wbank_in,
    output logic [FFT_N-1:0]       wa_in,
    output logic [2*FFT_DW-1:0]    wdw_in,
    output logic                   eng_start,
    output logic [BANK_BW-1:0]     eng_bank,
    output logic [3:0]             eng_log2len,
    output logic                   eng_ifft,
    input  logic                   eng_done,
    input  logic [BFP_W-1:0]       eng_bfpexp,
    output logic                   rd_valid,
    output logic [BANK_BW-1:0]     rd_bank,
    output logic [3:0]             rd_log2len,
    output logic [BFP_W-1:0]       rd_bfpexp,
    output logic [3*NUM_BANKS-1:0] bank_state,
    output logic                   err
);

    localparam int unsigned SLOTS = 2 ** BANK_BW;

    bank_state_t        state_q [SLOTS];
    bank_state_t        state_d [SLOTS];
    bank_desc_t         desc_q  [SLOTS];
    bank_desc_t         desc_d  [SLOTS];
    logic [BANK_BW-1:0] fill_ptr_q, fill_ptr_d;
    logic [BANK_BW-1:0] run_ptr_q, run_ptr_d;
    logic [BANK_BW-1:0] read_ptr_q, read_ptr_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               oor_q;

    logic               fill_free;
    logic               accept;
    logic [3:0]         fill_len;
    logic [FFT_N-1:0]   cnt_count;
    logic [FFT_N-1:0]   cnt_addr;
    logic               cnt_last;
    logic               start;
    logic               done_ok;
    logic               release_rd;

    function automatic logic [BANK_BW-1:0] next_ptr(input logic [BANK_BW-1:0] p);
        return (p == BANK_BW'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fill_free = (state_q[fill_ptr_q] == BankFree);
    assign s_ready   = oor_q && (fill_free || state_q[fill_ptr_q] == BankFilling);
    assign accept    = s_valid && s_ready;
    // length comes from cfg only on a frame's first sample, afterwards from the latched descriptor
    assign fill_len  = fill_free ? clamp_log2len(cfg_log2len, 4'(FFT_N))
                                 : desc_q[fill_ptr_q].log2len;

    var_bitrev_counter #(
        .N(FFT_N)
    ) u_counter (
        .clk_i    (clk),
        .rst_i    (rst),
        .inc_i    (accept),
        .log2len_i(fill_len),
        .count_o  (cnt_count),
        .addr_o   (cnt_addr),
        .last_o   (cnt_last)
    );

    assign wact_in  = accept;
    assign wbank_in = fill_ptr_q;
    assign wa_in    = cnt_addr;
    assign wdw_in   = accept ? {s_imag, s_real} : '0;

    assign start       = !busy_q && (state_q[run_ptr_q] == BankFull) && (autorun || run);
    assign done_ok     = eng_done && busy_q;
    assign eng_start   = start;
    assign eng_bank    = run_ptr_q;
    assign eng_log2len = desc_q[run_ptr_q].log2len;
    assign eng_ifft    = desc_q[run_ptr_q].ifft;

    assign rd_valid    = (state_q[read_ptr_q] == BankDone);
    assign release_rd  = fin && rd_valid;
    assign rd_bank     = read_ptr_q;
    assign rd_log2len  = desc_q[read_ptr_q].log2len;
    assign rd_bfpexp   = desc_q[read_ptr_q].bfpexp;
    assign err         = err_q;

    always_comb begin
        bank_state = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_state[3*i +: 3] = state_q[i];
        end
    end

    // Each event targets a bank in a different state, so all of them can land in one cycle.
    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        fill_ptr_d = fill_ptr_q;
        run_ptr_d  = run_ptr_q;
        read_ptr_d = read_ptr_q;
        busy_d     = busy_q;
        err_d      = err_q | (eng_done & ~busy_q);

        if (accept) begin
            if (fill_free) begin
                desc_d[fill_ptr_q].log2len = fill_len;
                desc_d[fill_ptr_q].ifft    = ifft;
                state_d[fill_ptr_q]        = BankFilling;
            end
            if (cnt_last) begin
                state_d[fill_ptr_q] = BankFull;
                fill_ptr_d          = next_ptr(fill_ptr_q);
            end
        end

        if (start) begin
            state_d[run_ptr_q] = BankRunning;
            busy_d             = 1'b1;
        end

        if (done_ok) begin
            desc_d[run_ptr_q].bfpexp = eng_bfpexp;
            state_d[run_ptr_q]       = BankDone;
            run_ptr_d                = next_ptr(run_ptr_q);
            busy_d                   = 1'b0;
        end

        if (release_rd) begin
            state_d[read_ptr_q] = BankFree;
            read_ptr_d          = next_ptr(read_ptr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= BankFree;
                desc_q[i]  <= '0;
            end
            fill_ptr_q <= '0;
            run_ptr_q  <= '0;
            read_ptr_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            fill_ptr_q <= fill_ptr_d;
            run_ptr_q  <= run_ptr_d;
            read_ptr_q <= read_ptr_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            oor_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with an emulated engine.
module tb_fft_frame_sequencer;

    localparam int DW = 16;
    localparam int NB = 2;
    localparam int N  = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      cfg_log2len = '0;
    logic            autorun = 1'b0, run = 1'b0, ifft = 1'b0, fin = 1'b0, s_valid = 1'b0;
    logic [DW-1:0]   s_real = '0, s_imag = '0;
    logic            eng_done = 1'b0;
    logic [7:0]      eng_bfpexp = '0;
    logic            s_ready, wact_in, eng_start, eng_ifft, rd_valid, err;
    logic [1:0]      wbank_in, eng_bank, rd_bank;
    logic [N-1:0]    wa_in;
    logic [2*DW-1:0] wdw_in;
    logic [3:0]      eng_log2len, rd_log2len;
    logic [7:0]      rd_bfpexp;
    logic [3*NB-1:0] bank_state;

    fft_frame_sequencer #(
        .FFT_MAX_LENGTH(1024),
        .FFT_DW        (DW),
        .NUM_BANKS     (NB),
        .BANK_BW       (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_log2len(cfg_log2len),
        .autorun    (autorun),
        .run        (run),
        .ifft       (ifft),
        .fin        (fin),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_real     (s_real),
        .s_imag     (s_imag),
        .wact_in    (wact_in),
        .wbank_in   (wbank_in),
        .wa_in      (wa_in),
        .wdw_in     (wdw_in),
        .eng_start  (eng_start),
        .eng_bank   (eng_bank),
        .eng_log2len(eng_log2len),
        .eng_ifft   (eng_ifft),
        .eng_done   (eng_done),
        .eng_bfpexp (eng_bfpexp),
        .rd_valid   (rd_valid),
        .rd_bank    (rd_bank),
        .rd_log2len (rd_log2len),
        .rd_bfpexp  (rd_bfpexp),
        .bank_state (bank_state),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic int clampl(input int c);
        if (c < 3) return 3;
        if (c > N) return N;
        return c;
    endfunction

    function automatic int brev(input int c, input int l);
        int r = 0;
        for (int i = 0; i < l; i++) begin
            if (((c >> i) & 1) != 0) r |= 1 << (l - 1 - i);
        end
        return r;
    endfunction

    // Reference model: states 0 free, 1 filling, 2 full, 3 running, 4 done.
    int m_st [NB];
    int m_len [NB];
    int m_ifft [NB];
    int m_exp [NB];
    int m_fill, m_run, m_rd, m_cnt;
    bit m_busy, m_err, m_oor;

    always @(negedge clk) begin
        int  L, exp_bs;
        bit  rdy, acc, st, rdv, pre_busy;
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_st[i] = 0; m_len[i] = 0; m_ifft[i] = 0; m_exp[i] = 0;
            end
            m_fill = 0; m_run = 0; m_rd = 0; m_cnt = 0;
            m_busy = 0; m_err = 0; m_oor = 0;
            chk("rst_s_ready", s_ready, 0);
            chk("rst_bank_state", bank_state, 0);
            chk("rst_err", err, 0);
            chk("rst_eng_start", eng_start, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_wact_in", wact_in, 0);
        end else begin
            rdy = m_oor && (m_st[m_fill] == 0 || m_st[m_fill] == 1);
            acc = s_valid && rdy;
            L   = (m_st[m_fill] == 0) ? clampl(int'(cfg_log2len)) : m_len[m_fill];
            st  = !m_busy && m_st[m_run] == 2 && (autorun || run);
            rdv = (m_st[m_rd] == 4);
            exp_bs = 0;
            for (int i = 0; i < NB; i++) exp_bs |= m_st[i] << (3 * i);

            chk("s_ready", s_ready, rdy);
            chk("wact_in", wact_in, acc);
            if (acc) begin
                chk("wbank_in", wbank_in, m_fill);
                chk("wa_in", wa_in, brev(m_cnt, L));
                chk("wdw_in", wdw_in, {s_imag, s_real});
            end
            chk("eng_start", eng_start, st);
            if (st || m_busy) begin
                chk("eng_bank", eng_bank, m_run);
                chk("eng_log2len", eng_log2len, m_len[m_run]);
                chk("eng_ifft", eng_ifft, m_ifft[m_run]);
            end
            chk("rd_valid", rd_valid, rdv);
            if (rdv) begin
                chk("rd_bank", rd_bank, m_rd);
                chk("rd_log2len", rd_log2len, m_len[m_rd]);
                chk("rd_bfpexp", rd_bfpexp, m_exp[m_rd]);
            end
            chk("bank_state", bank_state, exp_bs);
            chk("err", err, m_err);

            pre_busy = m_busy;
            if (acc) begin
                if (m_st[m_fill] == 0) begin
                    m_len[m_fill]  = L;
                    m_ifft[m_fill] = ifft;
                    m_st[m_fill]   = 1;
                end
                m_cnt++;
                if (m_cnt == (1 << L)) begin
                    m_st[m_fill] = 2;
                    m_cnt = 0;
                    m_fill = (m_fill + 1) % NB;
                end
            end
            if (st) begin
                m_st[m_run] = 3;
                m_busy = 1;
            end
            if (eng_done) begin
                if (pre_busy) begin
                    m_exp[m_run] = eng_bfpexp;
                    m_st[m_run]  = 4;
                    m_run  = (m_run + 1) % NB;
                    m_busy = 0;
                end else begin
                    m_err = 1;
                end
            end
            if (fin && rdv) begin
                m_st[m_rd] = 0;
                m_rd = (m_rd + 1) % NB;
            end
            m_oor = 1;
        end
    end

    // Engine emulation used by the autonomous scenarios.
    bit eng_auto = 0;
    bit spurious_ok = 0;
    bit eng_pending = 0;
    int eng_delay = 0;
    int eng_timer = 0;

    task automatic tick();
        #1;
        if (eng_auto && eng_start) begin
            eng_pending = 1;
            eng_timer = eng_delay;
        end
        @(posedge clk);
        #1;
        if (eng_auto) begin
            eng_done = 1'b0;
            if (eng_pending) begin
                if (eng_timer == 0) begin
                    eng_done = 1'b1;
                    eng_bfpexp = 8'($urandom);
                    eng_pending = 0;
                end else begin
                    eng_timer--;
                end
            end else if (spurious_ok && $urandom_range(0, 299) == 0) begin
                eng_done = 1'b1;
                eng_bfpexp = 8'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; fin = 1'b0; run = 1'b0; autorun = 1'b0;
        eng_done = 1'b0; eng_pending = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int wa_exp [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    initial begin
        bit found;
        int guard;

        // L=3 with clamped cfg, mid-frame cfg change, spurious done, run gating
        do_reset();
        #1 chk("oor_gate", s_ready, 0);
        tick();
        #1 chk("ready_after_reset", s_ready, 1);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        #1 chk("err_spurious", err, 1);
        chk("err_no_state_change", bank_state, 0);
        cfg_log2len = 4'd1;
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) cfg_log2len = 4'd4;
            s_real = 16'(k);
            s_imag = 16'(k + 100);
            #1 chk("l3_wact", wact_in, 1);
            chk("l3_wbank", wbank_in, 0);
            chk("l3_wa_bitrev", wa_in, wa_exp[k]);
            tick();
        end
        s_valid = 1'b0;
        #1 chk("l3_bank0_full", bank_state, 6'h02);
        chk("l3_no_autostart", eng_start, 0);
        tick(); tick(); tick();
        #1 chk("l3_wait_for_run", eng_start, 0);
        run = 1'b1;
        #1 chk("l3_start_on_run", eng_start, 1);
        chk("l3_clamp_low", eng_log2len, 3);
        tick();
        run = 1'b0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        #1 chk("l3_rd_valid_after_done", rd_valid, 1);
        fin = 1'b1;
        tick();
        fin = 1'b0;

        // Two manual frames (L=5, L=9), backpressure, exponents, fin reopening bank0
        do_reset();
        tick();
        cfg_log2len = 4'd5;
        s_valid = 1'b1;
        for (int k = 0; k < 32 + 512; k++) begin
            if (k == 32) cfg_log2len = 4'd9;
            tick();
        end
        #1 chk("bp_s_ready", s_ready, 0);
        chk("bp_no_write", wact_in, 0);
        chk("bp_both_full", bank_state, 6'h12);
        run = 1'b1;
        #1 chk("d2_start0", eng_start, 1);
        chk("d2_start0_len", eng_log2len, 5);
        tick();
        eng_done = 1'b1;
        eng_bfpexp = 8'hFD;
        tick();
        eng_done = 1'b0;
        #1 chk("d2_start1_next_cycle", eng_start, 1);
        chk("d2_start1_bank", eng_bank, 1);
        chk("d2_start1_len", eng_log2len, 9);
        chk("d2_rd_exp_m3", rd_bfpexp, 8'hFD);
        chk("d2_rd_len5", rd_log2len, 5);
        tick();
        run = 1'b0;
        eng_done = 1'b1;
        eng_bfpexp = 8'h02;
        tick();
        eng_done = 1'b0;
        #1 chk("d2_ready_held_by_done", s_ready, 0);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        #1 chk("d2_ready_after_fin", s_ready, 1);
        chk("d2_write_bank0", wact_in, 1);
        chk("d2_write_bank0_idx", wbank_in, 0);
        chk("d2_rd_bank1", rd_bank, 1);
        chk("d2_rd_len9", rd_log2len, 9);
        chk("d2_rd_exp_p2", rd_bfpexp, 8'h02);
        s_valid = 1'b0;
        tick();

        // autorun, two 1024-sample frames overlapping a long engine run
        do_reset();
        tick();
        eng_auto = 1;
        eng_delay = 1100;
        autorun = 1'b1;
        cfg_log2len = 4'd10;
        s_valid = 1'b1;
        for (int k = 0; k < 1024; k++) tick();
        cfg_log2len = 4'd15;
        for (int k = 0; k < 1024; k++) tick();
        s_valid = 1'b0;
        found = 0;
        guard = 0;
        while (!found && guard < 3000) begin
            tick();
            guard++;
            if (eng_done) found = 1;
        end
        chk("d3_done_seen", found, 1);
        #1 chk("d3_overlap_states", bank_state, 6'h13);
        tick();
        #1 chk("d3_start1_after_done", eng_start, 1);
        chk("d3_start1_bank", eng_bank, 1);
        chk("d3_clamp_high", eng_log2len, 10);
        tick();
        eng_auto = 0;
        eng_done = 1'b0;

        // reset mid-fill discards everything and restarts the count
        do_reset();
        tick();
        cfg_log2len = 4'd4;
        s_valid = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        #1 chk("midfill_rst_state", bank_state, 0);
        chk("midfill_rst_ready", s_ready, 0);
        s_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        s_valid = 1'b1;
        #1 chk("restart_wa0", wa_in, 0);
        chk("restart_wact", wact_in, 1);
        tick();
        #1 chk("restart_wa1", wa_in, 8);
        tick();
        s_valid = 1'b0;

        // randomized traffic
        do_reset();
        eng_auto = 1;
        spurious_ok = 1;
        for (int c = 0; c < 20000; c++) begin
            if (c % 500 == 0) autorun = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 3) == 0);
            fin = ($urandom_range(0, 4) == 0);
            s_valid = ($urandom_range(0, 9) < 7);
            cfg_log2len = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(8, 15))
                                                       : 4'($urandom_range(0, 6));
            ifft = 1'($urandom_range(0, 1));
            s_real = 16'($urandom);
            s_imag = 16'($urandom);
            eng_delay = $urandom_range(0, 30);
            if ($urandom_range(0, 4999) == 0) begin
                rst = 1'b1;
                eng_pending = 0;
            end else begin
                rst = 1'b0;
            end
            tick();
        end
        rst = 1'b0;
        s_valid = 1'b0;
        fin = 1'b0;
        run = 1'b0;
        spurious_ok = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
